// File: rtl/serial_alu_pkg.sv
// Shared types for the digit-serial ALU sequencer: operation encoding and digit-count helper.
package serial_alu_pkg;

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpAnd = 3'd2,
        OpOr  = 3'd3,
        OpXor = 3'd4,
        OpEq  = 3'd5,
        OpLtu = 3'd6
    } SerialAluOp;

    function automatic int unsigned digit_count(input int unsigned xlen,
                                                input int unsigned digit_w);
        return xlen / digit_w;
    endfunction

endpackage

// File: rtl/serial_alu_digit.sv
// Combinational one-digit ALU slice; b arrives already extended and inverted for SUB/LTU.
module serial_alu_digit
    import serial_alu_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4
) (
    input  SerialAluOp         i_op,
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    input  logic               i_carry,
    output logic [DIGIT_W-1:0] o_sum,
    output logic               o_carry,
    output logic               o_eq
);

    logic [DIGIT_W:0] w_add;

    assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_carry};
    assign o_eq  = (i_a == i_b);

    always_comb begin
        o_sum   = w_add[DIGIT_W-1:0];
        o_carry = 1'b0;
        case (i_op)
            OpAdd, OpSub, OpLtu: o_carry = w_add[DIGIT_W];
            OpAnd:               o_sum = i_a & i_b;
            OpOr:                o_sum = i_a | i_b;
            OpXor:               o_sum = i_a ^ i_b;
            OpEq:                o_sum = ~(i_a ^ i_b);
            default:             o_sum = w_add[DIGIT_W-1:0];
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Digit-serial ALU sequencer: one DIGIT_W slice per clock, with early exit once the
// upper digits of an ADD/SUB have settled or an EQ compare has mismatched.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DIGIT_W = 4,
    localparam int unsigned N      = digit_count(XLEN, DIGIT_W),
    localparam int unsigned LEN_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  SerialAluOp       i_op,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_w2_signed,
    input  logic [XLEN-1:0]  i_word1,
    input  logic [XLEN-1:0]  i_word2,
    output logic             o_busy,
    output logic             o_done,
    output logic [XLEN-1:0]  o_result,
    output logic             o_flag
);

    localparam logic [0:0]      StIdle     = 1'b0;
    localparam logic [0:0]      StRun      = 1'b1;
    localparam logic [LEN_W:0]  N_DIGITS   = (LEN_W + 1)'(N);
    localparam logic [XLEN-1:0] DIGIT_MASK = XLEN'({DIGIT_W{1'b1}});
    localparam logic [XLEN-1:0] SIGN_BIT   = XLEN'(1) << (DIGIT_W - 1);

    logic [0:0]       r_state;
    SerialAluOp       r_op;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic             r_w2_signed;
    logic             r_carry;
    logic             r_done;
    logic             r_flag;
    logic [XLEN-1:0]  r_word1;
    logic [XLEN-1:0]  r_word2;
    logic [XLEN-1:0]  r_result;

    logic [LEN_W:0]     w_idx_next;
    logic               w_is_arith;
    logic               w_invert;
    logic               w_ext;
    logic [DIGIT_W-1:0] w_a_cur;
    logic [DIGIT_W-1:0] w_b_cur;
    logic [DIGIT_W-1:0] w_b_next;
    logic [DIGIT_W-1:0] w_sum;
    logic               w_cout;
    logic               w_eq;
    logic               w_last;
    logic               w_settle;
    logic               w_finish;
    logic               w_flag_next;
    logic [XLEN-1:0]    w_result_next;

    function automatic logic [DIGIT_W-1:0] f_digit(input logic [XLEN-1:0] word,
                                                   input logic [LEN_W:0]  k);
        return DIGIT_W'(word >> (k * DIGIT_W));
    endfunction

    assign w_idx_next = {1'b0, r_idx} + {{LEN_W{1'b0}}, 1'b1};
    assign w_is_arith = (r_op == OpAdd) || (r_op == OpSub);
    assign w_invert   = (r_op == OpSub) || (r_op == OpLtu);
    assign w_ext      = r_w2_signed & (|(r_word2 & (SIGN_BIT << (r_len * DIGIT_W))));
    assign w_a_cur    = f_digit(r_word1, {1'b0, r_idx});

    // Effective word2 digits for the current and the following position.
    always_comb begin
        w_b_cur  = f_digit(r_word2, {1'b0, r_idx});
        w_b_next = f_digit(r_word2, w_idx_next);
        if (w_is_arith && (r_idx > r_len)) begin
            w_b_cur = {DIGIT_W{w_ext}};
        end
        if (w_is_arith && (w_idx_next > {1'b0, r_len})) begin
            w_b_next = {DIGIT_W{w_ext}};
        end
        if (w_invert) begin
            w_b_cur  = ~w_b_cur;
            w_b_next = ~w_b_next;
        end
    end

    serial_alu_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .i_op    (r_op),
        .i_a     (w_a_cur),
        .i_b     (w_b_cur),
        .i_carry (r_carry),
        .o_sum   (w_sum),
        .o_carry (w_cout),
        .o_eq    (w_eq)
    );

    // Zero ext with no carry, or all-ones ext with carry, leaves the upper word1 digits intact.
    assign w_last   = (w_idx_next == N_DIGITS);
    assign w_settle = w_is_arith && (r_idx >= r_len) && !w_last &&
                      (((w_b_next == '0) && !w_cout) || ((w_b_next == '1) && w_cout));
    assign w_finish = w_last || w_settle || ((r_op == OpEq) && !w_eq);

    assign w_result_next = (r_result & ~(DIGIT_MASK << (r_idx * DIGIT_W))) |
                           (XLEN'(w_sum) << (r_idx * DIGIT_W));

    always_comb begin
        w_flag_next = 1'b0;
        case (r_op)
            OpAdd, OpSub: w_flag_next = w_cout;
            OpLtu:        w_flag_next = ~w_cout;
            OpEq:         w_flag_next = w_eq;
            default:      w_flag_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_op        <= OpAdd;
            r_len       <= '0;
            r_idx       <= '0;
            r_w2_signed <= 1'b0;
            r_carry     <= 1'b0;
            r_done      <= 1'b0;
            r_flag      <= 1'b0;
            r_word1     <= '0;
            r_word2     <= '0;
            r_result    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state     <= StRun;
                        r_op        <= i_op;
                        r_len       <= i_len;
                        r_w2_signed <= i_w2_signed;
                        r_word1     <= i_word1;
                        r_word2     <= i_word2;
                        r_result    <= i_word1;
                        r_idx       <= '0;
                        r_carry     <= (i_op == OpSub) || (i_op == OpLtu);
                    end
                end
                StRun: begin
                    r_result <= w_result_next;
                    r_carry  <= w_cout;
                    r_idx    <= w_idx_next[LEN_W-1:0];
                    if (w_finish) begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                        r_flag  <= w_flag_next;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy   = (r_state == StRun);
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_flag   = r_flag;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq: directed cases, a mid-op reset and random traffic.
module tb_serial_alu_seq;
    import serial_alu_pkg::*;

    localparam int XLEN = 32;
    localparam int DW   = 4;
    localparam int N    = XLEN / DW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    SerialAluOp  i_op = OpAdd;
    logic [2:0]  i_len = '0;
    logic        i_w2_signed = 1'b0;
    logic [31:0] i_word1 = '0;
    logic [31:0] i_word2 = '0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
    logic        o_flag;

    serial_alu_seq #(
        .XLEN    (XLEN),
        .DIGIT_W (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_op        (i_op),
        .i_len       (i_len),
        .i_w2_signed (i_w2_signed),
        .i_word1     (i_word1),
        .i_word2     (i_word2),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_result    (o_result),
        .o_flag      (o_flag)
    );

    typedef struct {
        logic [31:0] res;
        logic        flg;
        int          lat;
        int          start_cyc;
        SerialAluOp  op;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endfunction

    // Reference: whole-word arithmetic, plus the digit count at which the upper part settles.
    function automatic void model(input SerialAluOp op, input logic [2:0] len, input logic sgn,
                                  input logic [31:0] w1, input logic [31:0] w2,
                                  output logic [31:0] res, output logic flg, output int lat);
        int          l;
        logic [63:0] mask, b, cin, sum, m, cy;
        logic [31:0] eff;
        logic [3:0]  da, db, nd;
        l    = int'(len);
        lat  = N;
        flg  = 1'b0;
        res  = w1;
        mask = (64'd1 << ((l + 1) * DW)) - 64'd1;
        eff  = w2 & mask[31:0];
        if (sgn && w2[(l + 1) * DW - 1]) eff = eff | ~mask[31:0];
        case (op)
            OpAdd, OpSub: begin
                b   = (op == OpSub) ? {32'd0, ~eff} : {32'd0, eff};
                cin = (op == OpSub) ? 64'd1 : 64'd0;
                sum = {32'd0, w1} + b + cin;
                res = sum[31:0];
                flg = sum[32];
                for (int k = l; k < N - 1; k++) begin
                    m  = (64'd1 << ((k + 1) * DW)) - 64'd1;
                    cy = (({32'd0, w1} & m) + (b & m) + cin) >> ((k + 1) * DW);
                    nd = 4'(b >> ((k + 1) * DW));
                    if ((cy == 64'd0 && nd == 4'h0) || (cy == 64'd1 && nd == 4'hF)) begin
                        lat = k + 1;
                        break;
                    end
                end
            end
            OpAnd: res = w1 & w2;
            OpOr:  res = w1 | w2;
            OpXor: res = w1 ^ w2;
            OpEq: begin
                flg = 1'b1;
                for (int k = 0; k < N; k++) begin
                    da = 4'(w1 >> (k * DW));
                    db = 4'(w2 >> (k * DW));
                    res[k * DW +: DW] = ~(da ^ db);
                    if (da != db) begin
                        flg = 1'b0;
                        lat = k + 1;
                        break;
                    end
                end
            end
            OpLtu: begin
                res = w1 - w2;
                flg = (w1 < w2);
            end
            default: res = w1;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done with result %h, required no done", o_result);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.op.name(), "_result"}, o_result, mon_e.res);
                chk({mon_e.op.name(), "_flag"}, 32'(o_flag), 32'(mon_e.flg));
                chk({mon_e.op.name(), "_latency"}, 32'(cyc - mon_e.start_cyc - 1), 32'(mon_e.lat));
            end
        end
    end

    task automatic die(input string why);
        $display("FAIL %s: got timeout, required progress", why);
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "bench stopped");
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic issue(input SerialAluOp op, input logic [2:0] len, input logic sgn,
                         input logic [31:0] w1, input logic [31:0] w2,
                         input bit push, input int hold);
        int   guard = 0;
        exp_t e;
        while (o_busy) begin
            @(negedge clk);
            guard++;
            if (guard > 200) die("wait_idle");
        end
        i_op        = op;
        i_len       = len;
        i_w2_signed = sgn;
        i_word1     = w1;
        i_word2     = w2;
        i_start     = 1'b1;
        if (push) begin
            model(op, len, sgn, w1, w2, e.res, e.flg, e.lat);
            e.start_cyc = cyc;
            e.op        = op;
            sb.push_back(e);
        end
        @(posedge clk);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        i_word1 = $urandom;
        i_word2 = $urandom;
        i_len   = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (o_busy || sb.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 200) die("drain");
        end
    endtask

    initial begin
        SerialAluOp  op;
        logic [31:0] w1, w2;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_result", o_result, 32'd0);
        chk("reset_flag", 32'(o_flag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(OpAdd, 3'd2, 1'b1, 32'h7B, 32'h002, 1'b1, 0);
        issue(OpAdd, 3'd0, 1'b0, 32'hFF, 32'h4, 1'b1, 0);
        issue(OpAdd, 3'd2, 1'b1, 32'h0, 32'h800, 1'b1, 0);
        issue(OpEq, 3'd0, 1'b0, 32'h12, 32'h22, 1'b1, 0);
        issue(OpEq, 3'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 0);
        issue(OpAdd, 3'd0, 1'b1, 32'hFFF, 32'hF, 1'b1, 0);
        issue(OpSub, 3'd0, 1'b0, 32'h100, 32'h1, 1'b1, 0);
        issue(OpSub, 3'd7, 1'b0, 32'h3, 32'h5, 1'b1, 0);
        // Start held high for the whole operation must yield exactly one result.
        issue(OpLtu, 3'd0, 1'b0, 32'd5, 32'd7, 1'b1, N);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ltu_held_start_idle", 32'(o_busy), 32'd0);

        // Reset in the fourth cycle of an eight-digit op: no done, outputs back to reset values.
        issue(OpXor, 3'd0, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(o_busy), 32'd0);
        chk("midreset_result", o_result, 32'd0);
        chk("midreset_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(OpOr, 3'd0, 1'b0, 32'h12340000, 32'h00005678, 1'b1, 0);

        for (int i = 0; i < 80; i++) begin
            op = SerialAluOp'(3'($urandom_range(0, 6)));
            w1 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 3))
                0:       w2 = 32'($urandom_range(0, 15));
                1:       w2 = ~32'($urandom_range(0, 15));
                2:       w2 = w1 ^ (32'h1 << (4 * $urandom_range(0, 7)));
                default: w2 = $urandom;
            endcase
            issue(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), w1, w2, 1'b1, 0);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
        end

        wait_idle();
        repeat (4) @(negedge clk);
        chk("final_pending", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
